// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-bus handshake signals of the IF/MEM memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              flush;
  logic              d_req;
  logic              d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_stall;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;
  modport slave (
    input  if_req, if_addr, flush, d_req, d_we, d_be, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output if_rvalid, if_rdata, if_stall, d_rvalid, d_rdata, mem_stall, mem_req, mem_we, mem_be,
           mem_addr, mem_wdata, err
  );
  modport master (
    output if_req, if_addr, flush, d_req, d_we, d_be, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  if_rvalid, if_rdata, if_stall, d_rvalid, d_rdata, mem_stall, mem_req, mem_we, mem_be,
           mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding IF/MEM arbiter for a unified memory port; define MEM_PORT_ARB_RR_EN for round-robin priority
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_nx;
  logic drop, drop_nx;
  logic [CW-1:0] cnt;
  logic hold_v, hold_d;
  logic any_req, held_ok, pick_d, prio_d, grant, busy, done, tmo, if_rv, d_rv, req;
`ifdef MEM_PORT_ARB_RR_EN
  logic ptr_d;
  // last granted port; the other port wins the next contention
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_d <= 1'b1;
    else if (grant) ptr_d <= pick_d;
  assign prio_d = ~ptr_d;
`else
  assign prio_d = 1'b1;
`endif
  assign any_req = bus.if_req | bus.d_req;
  assign held_ok = hold_v & (hold_d ? bus.d_req : bus.if_req);
  assign pick_d  = held_ok ? hold_d : bus.d_req & (~bus.if_req | prio_d);
  assign grant   = (state == IDLE) & any_req & bus.mem_gnt;
  assign busy    = state != IDLE;
  assign tmo     = busy & ~bus.mem_rvalid & (cnt == CW'(TIMEOUT - 1));
  assign done    = bus.mem_rvalid | tmo;
  assign if_rv   = (state == BUSY_I) & bus.mem_rvalid & ~drop & ~bus.flush;
  assign d_rv    = (state == BUSY_D) & bus.mem_rvalid;
  assign req     = rst_n & (state == IDLE) & any_req;
  // next state and fetch-drop flag
  always_comb begin
    state_nx = busy ? (done ? IDLE : state) : (grant ? (pick_d ? BUSY_D : BUSY_I) : IDLE);
    drop_nx  = busy ? (state == BUSY_I) & ~done & (drop | bus.flush) : grant & ~pick_d & bus.flush;
  end
  // state, drop flag, watchdog counter and the un-granted winner lock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      drop   <= 1'b0;
      cnt    <= '0;
      hold_v <= 1'b0;
      hold_d <= 1'b0;
    end else begin
      state  <= state_nx;
      drop   <= drop_nx;
      cnt    <= busy ? cnt + CW'(1) : '0;
      hold_v <= (state == IDLE) & any_req & ~bus.mem_gnt;
      hold_d <= pick_d;
    end
  // request bus, response routing and stall requests, all forced low in reset
  always_comb begin
    bus.mem_req   = req;
    bus.mem_we    = req & pick_d & bus.d_we;
    bus.mem_be    = !req ? '0 : pick_d ? bus.d_be : '1;
    bus.mem_addr  = !req ? '0 : pick_d ? bus.d_addr : bus.if_addr;
    bus.mem_wdata = (req & pick_d) ? bus.d_wdata : '0;
    bus.if_rvalid = rst_n & if_rv;
    bus.if_rdata  = (rst_n & if_rv) ? bus.mem_rdata : '0;
    bus.d_rvalid  = rst_n & d_rv;
    bus.d_rdata   = (rst_n & d_rv) ? bus.mem_rdata : '0;
    bus.if_stall  = rst_n & bus.if_req & ~if_rv;
    bus.mem_stall = rst_n & bus.d_req & ~d_rv;
    bus.err       = rst_n & tmo;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the 5-stage pipeline, with one outstanding transaction at a time. It produces per-stage stall requests that feed the hazard unit alongside load-use stalls. It discards in-flight fetch responses that are squashed by a branch/jump flush, and runs a response watchdog.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles waiting for mem_rvalid_i before abort (≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_rvalid_o
- if_addr_i  in  ADDR_W  fetch address
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch data
- if_stall_o  out  1  stall request for PC/IF-ID
- flush_i  in  1  pipeline redirect (same signal as IF/ID flush)
- d_req_i  in  1  data request, held until d_rvalid_o
- d_we_i  in  1  1 = store
- d_be_i  in  DATA_W/8  byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rvalid_o  out  1  load data / store ack (1-cycle pulse)
- d_rdata_o  out  DATA_W  load data
- mem_stall_o  out  1  stall request for MEM and upstream
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory request bus
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  response valid (reads and writes)
- mem_rdata_i  in  DATA_W  read data
- err_o  out  1  1-cycle pulse on watchdog timeout

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: pick winner among asserted if_req_i/d_req_i; drive mem_req_o=1 with winner's fields (fetch: we=0, be=all ones, wdata=0). On mem_gnt_i go to BUSY_I or BUSY_D. Without mem_gnt_i, re-arbitrate next cycle (winner may change only if the requester dropped).
- Default priority: data over fetch (older instruction first).
- BUSY_x: mem_req_o=0. On mem_rvalid_i: route mem_rdata_i to owner, pulse owner's rvalid_o, return to IDLE. A new request can be issued the following cycle (no back-to-back in the rvalid cycle).
- Flush: flush_i while in BUSY_I (or in the IDLE grant cycle with fetch winning) sets drop flag. The matching response is consumed with if_rvalid_o=0 and the flag cleared. flush_i in BUSY_D has no effect.
- if_stall_o = if_req_i & ~if_rvalid_o; mem_stall_o = d_req_i & ~d_rvalid_o.
- Watchdog: a counter clears on entering BUSY_x and increments each BUSY cycle. When it reaches TIMEOUT-1 without mem_rvalid_i: pulse err_o, go to IDLE, no rvalid to owner (owner stays stalled and re-requests).
- mem_rvalid_i in IDLE (stale/post-reset) is ignored.

## Timing
- Reset (rst_n low, async): state IDLE, drop flag 0, counter 0, RR pointer to data. All outputs 0 while rst_n low, mem_req_o included.
- Request-path outputs and rvalid/rdata routing are combinational from state and inputs. State, drop flag, counter and pointer are registered.
- Minimum latency: req cycle with gnt (cycle 0) → rvalid at cycle ≥1, as the memory dictates.
- Simultaneous if_req_i and d_req_i in IDLE: one grant per the priority rule; the loser stalls.
- flush_i coincident with mem_rvalid_i in BUSY_I: the response is dropped.
- rst_n deasserted mid-transaction: the outstanding response is discarded as a stale IDLE rvalid.

## Configuration
- MEM_PORT_ARB_RR_EN defined: round-robin priority. A 1-bit pointer holds the last granted port. When both request, grant goes to the other port. The pointer updates on each mem_gnt_i.
- Not defined: fixed data-over-fetch priority, and no pointer register.

## Test plan
- Fetch only: if_addr_i=0x100, gnt at cycle 0, mem_rvalid_i at cycle 2 with 0x00000013 → if_rvalid_o=1 and if_rdata_o=0x13 at cycle 2; if_stall_o=1 during cycles 0–1.
- Contention: if_req_i and d_req_i (load 0x2000) both asserted → data granted first. Fetch granted the cycle after d_rvalid_o. With MEM_PORT_ARB_RR_EN and the previous grant = data, fetch is granted first instead.
- Store: d_we_i=1, be=4'b0011, wdata=0xDEADBEEF → mem bus carries the same fields; d_rvalid_o pulses on mem_rvalid_i; d_rdata_o is ignored.
- Flush: fetch granted, flush_i at cycle 1, rvalid at cycle 3 → if_rvalid_o stays 0. A new fetch at cycle 4 to 0x200 completes normally.
- Timeout with TIMEOUT=4: no mem_rvalid_i after grant → err_o pulses exactly once at the 4th BUSY cycle, state returns to IDLE, and a late mem_rvalid_i is ignored.
- Async reset asserted in BUSY_D → all outputs 0 immediately. After release, a stale mem_rvalid_i produces no d_rvalid_o.
